// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU control FSM: states, opcodes,
// ALU control codes and ALU operand-B selects.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC_R,
        ST_EXEC_I,
        ST_ADDR,
        ST_MEM_RD,
        ST_MEM_WR,
        ST_WB_ALU,
        ST_WB_MEM,
        ST_BRANCH,
        ST_HALT
    } state_t;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_IMM   = 4'b0010;
    localparam logic [3:0] OP_LOAD  = 4'b1000;
    localparam logic [3:0] OP_STORE = 4'b1011;
    localparam logic [3:0] OP_BEQ   = 4'b0100;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    localparam logic [1:0] ALU_FUNC = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_ADD  = 2'b10;
    localparam logic [1:0] ALU_IMM  = 2'b11;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_TWO    = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BR_OFF = 2'b11;

    // States that wait on memReady and are therefore guarded by the watchdog.
    function automatic logic is_mem_state(state_t s);
        return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control/status bundle between the main control FSM (master) and the
// datapath (slave).
interface multicycle_control_if #(
    parameter int COUNT_W = 16
);
    logic [3:0]         opcode;
    logic               zero;
    logic               memReady;
    logic [1:0]         aluControlOp;
    logic               aluSrcA;
    logic [1:0]         aluSrcB;
    logic               pcWrite;
    logic               pcWriteCond;
    logic               pcSource;
    logic               irWrite;
    logic               memRead;
    logic               memWrite;
    logic               regWrite;
    logic               memToReg;
    logic               halted;
    logic               illegalOp;
    logic               busError;
    logic [COUNT_W-1:0] retiredCount;

    modport master (
        input  opcode, zero, memReady,
        output aluControlOp, aluSrcA, aluSrcB, pcWrite, pcWriteCond, pcSource,
               irWrite, memRead, memWrite, regWrite, memToReg, halted,
               illegalOp, busError, retiredCount
    );

    modport slave (
        output opcode, zero, memReady,
        input  aluControlOp, aluSrcA, aluSrcB, pcWrite, pcWriteCond, pcSource,
               irWrite, memRead, memWrite, regWrite, memToReg, halted,
               illegalOp, busError, retiredCount
    );
endinterface

// File: rtl/multicycle_control_mem_watchdog.sv
// Memory-wait watchdog: counts stalled cycles while a memory access is
// pending and flags expiry on the last allowed cycle.
module mem_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic memReady,
    input  logic stateChange,
    output logic expire
);
    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = 8'd0;
        if (active && !memReady && !stateChange) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // memReady on the final cycle wins over expiry.
    assign expire = active && !memReady && (cnt_q == LAST);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM: sequences fetch/decode/execute/memory/
// writeback, decodes datapath enables from state, counts retired instructions.
module multicycle_control #(
    parameter int TIMEOUT = 16,
    parameter int COUNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    multicycle_control_if.master bus
);
    import cpu_ctrl_pkg::*;

    state_t             state_q, state_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               retire;
    logic               illegal;
    logic               expire;
    logic               mem_active;
    logic               state_change;

    assign mem_active   = is_mem_state(state_q);
    assign state_change = (state_d != state_q);

    mem_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk         (clk),
        .rst         (rst),
        .active      (mem_active),
        .memReady    (bus.memReady),
        .stateChange (state_change),
        .expire      (expire)
    );

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        illegal = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (bus.memReady)  state_d = ST_DECODE;
                else if (expire)   state_d = ST_HALT;
            end
            ST_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE: state_d = ST_EXEC_R;
                    OP_IMM:   state_d = ST_EXEC_I;
                    OP_LOAD,
                    OP_STORE: state_d = ST_ADDR;
                    OP_BEQ:   state_d = ST_BRANCH;
                    OP_HALT:  state_d = ST_HALT;
                    default: begin
                        state_d = ST_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            ST_EXEC_R, ST_EXEC_I: state_d = ST_WB_ALU;
            ST_ADDR:   state_d = (bus.opcode == OP_LOAD) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD: begin
                if (bus.memReady)  state_d = ST_WB_MEM;
                else if (expire)   state_d = ST_HALT;
            end
            ST_MEM_WR: begin
                if (bus.memReady) begin
                    state_d = ST_FETCH;
                    retire  = 1'b1;
                end else if (expire) begin
                    state_d = ST_HALT;
                end
            end
            ST_WB_ALU, ST_WB_MEM, ST_BRANCH: begin
                state_d = ST_FETCH;
                retire  = 1'b1;
            end
            default: state_d = ST_HALT;
        endcase
    end

    assign count_d = retire ? count_q + COUNT_W'(1) : count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Same-cycle strobes are held off during reset so nothing is written on release.
    always_comb begin
        bus.aluControlOp = ALU_FUNC;
        bus.aluSrcA      = 1'b0;
        bus.aluSrcB      = SRCB_REG;
        bus.pcWrite      = 1'b0;
        bus.pcWriteCond  = 1'b0;
        bus.pcSource     = 1'b0;
        bus.irWrite      = 1'b0;
        bus.memRead      = 1'b0;
        bus.memWrite     = 1'b0;
        bus.regWrite     = 1'b0;
        bus.memToReg     = 1'b0;
        bus.halted       = 1'b0;
        bus.illegalOp    = illegal && !rst;
        bus.busError     = expire && !rst;
        case (state_q)
            ST_FETCH: begin
                bus.memRead      = 1'b1;
                bus.aluSrcB      = SRCB_TWO;
                bus.aluControlOp = ALU_ADD;
                bus.irWrite      = bus.memReady && !rst;
                bus.pcWrite      = bus.memReady && !rst;
            end
            ST_DECODE: begin
                bus.aluSrcB      = SRCB_BR_OFF;
                bus.aluControlOp = ALU_ADD;
            end
            ST_EXEC_R: begin
                bus.aluSrcA      = 1'b1;
                bus.aluSrcB      = SRCB_REG;
                bus.aluControlOp = ALU_FUNC;
            end
            ST_EXEC_I: begin
                bus.aluSrcA      = 1'b1;
                bus.aluSrcB      = SRCB_IMM;
                bus.aluControlOp = ALU_IMM;
            end
            ST_ADDR: begin
                bus.aluSrcA      = 1'b1;
                bus.aluSrcB      = SRCB_IMM;
                bus.aluControlOp = ALU_ADD;
            end
            ST_MEM_RD: bus.memRead  = 1'b1;
            ST_MEM_WR: bus.memWrite = 1'b1;
            ST_WB_ALU: bus.regWrite = 1'b1;
            ST_WB_MEM: begin
                bus.regWrite = 1'b1;
                bus.memToReg = 1'b1;
            end
            ST_BRANCH: begin
                bus.aluSrcA      = 1'b1;
                bus.aluSrcB      = SRCB_REG;
                bus.aluControlOp = ALU_SUB;
                bus.pcSource     = 1'b1;
                bus.pcWriteCond  = bus.zero;
            end
            ST_HALT: bus.halted = 1'b1;
            default: ;
        endcase
    end

    assign bus.retiredCount = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction phase model driven by
// random opcodes and wait lengths, plus directed timeout/reset/halt steps.
module tb_multicycle_control;
    localparam int TO = 4;
    localparam int CW = 4;

    localparam int P_FETCH = 0, P_DECODE = 1, P_EXEC_R = 2, P_EXEC_I = 3,
                   P_ADDR = 4, P_MEM_RD = 5, P_MEM_WR = 6, P_WB_ALU = 7,
                   P_WB_MEM = 8, P_BRANCH = 9, P_HALT = 10;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   exp_cnt;

    multicycle_control_if #(.COUNT_W(CW)) bus ();

    multicycle_control #(.TIMEOUT(TO), .COUNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no end, required end of test");
        $fatal(1);
    end

    // Control outputs expected in each phase, straight from the instruction table.
    function automatic logic [15:0] exp_word(int ph, logic mr, logic z, logic be, logic ill);
        logic [1:0] aop, sb;
        logic sa, pw, pwc, ps, irw, mrd, mwr, rw, m2r, hlt;
        aop = 2'b00; sb = 2'b00; sa = 0; pw = 0; pwc = 0; ps = 0;
        irw = 0; mrd = 0; mwr = 0; rw = 0; m2r = 0; hlt = 0;
        case (ph)
            P_FETCH:  begin mrd = 1; sb = 2'b01; aop = 2'b10; irw = mr; pw = mr; end
            P_DECODE: begin sb = 2'b11; aop = 2'b10; end
            P_EXEC_R: begin sa = 1; sb = 2'b00; aop = 2'b00; end
            P_EXEC_I: begin sa = 1; sb = 2'b10; aop = 2'b11; end
            P_ADDR:   begin sa = 1; sb = 2'b10; aop = 2'b10; end
            P_MEM_RD: mrd = 1;
            P_MEM_WR: mwr = 1;
            P_WB_ALU: rw = 1;
            P_WB_MEM: begin rw = 1; m2r = 1; end
            P_BRANCH: begin sa = 1; sb = 2'b00; aop = 2'b01; ps = 1; pwc = z; end
            P_HALT:   hlt = 1;
            default: ;
        endcase
        return {aop, sa, sb, pw, pwc, ps, irw, mrd, mwr, rw, m2r, hlt, ill, be};
    endfunction

    function automatic logic [15:0] dut_word();
        return {bus.aluControlOp, bus.aluSrcA, bus.aluSrcB, bus.pcWrite, bus.pcWriteCond,
                bus.pcSource, bus.irWrite, bus.memRead, bus.memWrite, bus.regWrite,
                bus.memToReg, bus.halted, bus.illegalOp, bus.busError};
    endfunction

    function automatic logic is_legal(logic [3:0] op);
        return op inside {4'b0000, 4'b0010, 4'b1000, 4'b1011, 4'b0100, 4'b1111};
    endfunction

    task automatic chk_word(input string tag, input logic [15:0] exp);
        logic [15:0] obs;
        obs = dut_word();
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed controls %b, expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag);
        logic [CW-1:0] exp;
        exp = CW'(exp_cnt);
        n_checks++;
        assert (bus.retiredCount === exp) else begin
            n_fail++;
            $error("FAIL %s_count: observed %0d, expected %0d", tag, bus.retiredCount, exp);
        end
    endtask

    // One clock: called just after a rising edge; checks mid-cycle.
    task automatic cyc(input int ph, input logic mr, input logic z, input logic be,
                       input logic ill, input string tag);
        bus.memReady = mr;
        bus.zero     = z;
        @(negedge clk);
        chk_word(tag, exp_word(ph, mr, z, be, ill));
        chk_cnt(tag);
        @(posedge clk);
        #1;
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic do_reset(input string tag);
        rst = 1'b1;
        bus.memReady = 1'b1;
        #1;
        exp_cnt = 0;
        chk_word(tag, exp_word(P_FETCH, 1'b0, 1'b0, 1'b0, 1'b0));
        chk_cnt(tag);
        @(posedge clk);
        #1;
        chk_word({tag, "_held"}, exp_word(P_FETCH, 1'b0, 1'b0, 1'b0, 1'b0));
        rst = 1'b0;
    endtask

    task automatic run_fetch(input int fw, input string tag);
        for (int i = 0; i <= fw; i++) begin
            bus.opcode = 4'($urandom_range(0, 15));
            cyc(P_FETCH, i == fw, rbit(), 1'b0, 1'b0, tag);
        end
    endtask

    task automatic run_instr(input logic [3:0] op, input logic z, input int fw,
                             input int mw, input string tag);
        logic ill;
        run_fetch(fw, tag);
        bus.opcode = op;
        ill = !is_legal(op);
        cyc(P_DECODE, rbit(), rbit(), 1'b0, ill, tag);
        if (ill) return;
        case (op)
            4'b0000: begin
                cyc(P_EXEC_R, rbit(), rbit(), 0, 0, tag);
                cyc(P_WB_ALU, rbit(), rbit(), 0, 0, tag);
                exp_cnt = (exp_cnt + 1) % (1 << CW);
            end
            4'b0010: begin
                cyc(P_EXEC_I, rbit(), rbit(), 0, 0, tag);
                cyc(P_WB_ALU, rbit(), rbit(), 0, 0, tag);
                exp_cnt = (exp_cnt + 1) % (1 << CW);
            end
            4'b1000: begin
                cyc(P_ADDR, rbit(), rbit(), 0, 0, tag);
                for (int i = 0; i <= mw; i++) cyc(P_MEM_RD, i == mw, rbit(), 0, 0, tag);
                cyc(P_WB_MEM, rbit(), rbit(), 0, 0, tag);
                exp_cnt = (exp_cnt + 1) % (1 << CW);
            end
            4'b1011: begin
                cyc(P_ADDR, rbit(), rbit(), 0, 0, tag);
                for (int i = 0; i <= mw; i++) cyc(P_MEM_WR, i == mw, rbit(), 0, 0, tag);
                exp_cnt = (exp_cnt + 1) % (1 << CW);
            end
            4'b0100: begin
                cyc(P_BRANCH, rbit(), z, 0, 0, tag);
                exp_cnt = (exp_cnt + 1) % (1 << CW);
            end
            default: begin
                for (int i = 0; i < 5; i++) begin
                    bus.opcode = 4'($urandom_range(0, 15));
                    cyc(P_HALT, rbit(), rbit(), 0, 0, tag);
                end
            end
        endcase
    endtask

    task automatic run_mem_timeout(input logic [3:0] op, input string tag);
        int ph;
        ph = (op == 4'b1000) ? P_MEM_RD : P_MEM_WR;
        run_fetch(0, tag);
        bus.opcode = op;
        cyc(P_DECODE, rbit(), 0, 0, 0, tag);
        cyc(P_ADDR, rbit(), 0, 0, 0, tag);
        for (int i = 0; i < TO; i++) cyc(ph, 1'b0, 0, i == TO - 1, 0, tag);
        for (int i = 0; i < 4; i++) cyc(P_HALT, rbit(), rbit(), 0, 0, tag);
    endtask

    initial begin
        logic [3:0] op;
        n_checks = 0;
        n_fail   = 0;
        exp_cnt  = 0;
        rst = 1'b1;
        bus.opcode   = 4'b0000;
        bus.zero     = 1'b0;
        bus.memReady = 1'b1;
        #2;
        chk_word("reset", exp_word(P_FETCH, 1'b0, 1'b0, 1'b0, 1'b0));
        chk_cnt("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_instr(4'b0000, 1'b0, 0, 0, "rtype_fast");
        run_instr(4'b1000, 1'b0, 0, 3, "load_wait3");
        run_instr(4'b1011, 1'b0, 1, 2, "store_wait");
        run_instr(4'b0100, 1'b1, 0, 0, "beq_taken");
        run_instr(4'b0100, 1'b0, 0, 0, "beq_not_taken");
        run_instr(4'b0111, 1'b0, 0, 0, "illegal_0111");

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 5) == 5) begin
                do op = 4'($urandom_range(0, 15)); while (is_legal(op));
            end else begin
                case ($urandom_range(0, 4))
                    0: op = 4'b0000;
                    1: op = 4'b0010;
                    2: op = 4'b1000;
                    3: op = 4'b1011;
                    default: op = 4'b0100;
                endcase
            end
            run_instr(op, rbit(), $urandom_range(0, TO - 1), $urandom_range(0, TO - 1), "random");
        end

        for (int i = 0; i < TO; i++) cyc(P_FETCH, 1'b0, 0, i == TO - 1, 0, "fetch_timeout");
        for (int i = 0; i < 5; i++) cyc(P_HALT, rbit(), rbit(), 0, 0, "timeout_halt");
        do_reset("reset_after_timeout");
        run_instr(4'b0010, 1'b0, TO - 1, 0, "fetch_ready_last");

        run_mem_timeout(4'b1011, "store_timeout");
        do_reset("reset_after_store_to");
        run_mem_timeout(4'b1000, "load_timeout");
        do_reset("reset_after_load_to");

        run_instr(4'b0000, 1'b0, 0, 0, "pre_async");
        run_fetch(0, "async_rst");
        bus.opcode = 4'b1011;
        cyc(P_DECODE, 0, 0, 0, 0, "async_rst");
        cyc(P_ADDR, 0, 0, 0, 0, "async_rst");
        bus.memReady = 1'b0;
        #2;
        chk_word("mem_wr_before_rst", exp_word(P_MEM_WR, 0, 0, 0, 0));
        rst = 1'b1;
        bus.memReady = 1'b1;
        #1;
        exp_cnt = 0;
        chk_word("async_rst_mid_wr", exp_word(P_FETCH, 0, 0, 0, 0));
        chk_cnt("async_rst_mid_wr");
        @(posedge clk);
        #1;
        chk_word("async_rst_held", exp_word(P_FETCH, 0, 0, 0, 0));
        chk_cnt("async_rst_held");
        rst = 1'b0;

        run_instr(4'b1111, 1'b0, 0, 0, "halt_op");
        do_reset("reset_after_halt");
        run_instr(4'b0010, 1'b0, 0, 0, "after_halt");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
